// File: rtl/cam_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cam_pkg: shared constants, FSM state type and XOR helper for cam_link    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package cam_pkg;

  localparam logic [7:0] STX        = 8'h02;
  localparam logic [7:0] ETX        = 8'h03;

  localparam logic [7:0] ST_OK      = 8'h02;
  localparam logic [7:0] ST_FRAME   = 8'h15;
  localparam logic [7:0] ST_CS      = 8'h16;
  localparam logic [7:0] ST_TIMEOUT = 8'h17;

  localparam int MAX_MSG_BYTES = 64;
  localparam int XOR_BITS      = 8 * MAX_MSG_BYTES;

  typedef enum logic [2:0] {
    S_RX_IDLE  = 3'd0,
    S_RX_BITS  = 3'd1,
    S_CHECK    = 3'd2,
    S_DISPATCH = 3'd3,
    S_BUILD    = 3'd4,
    S_TX       = 3'd5
  } cam_state_t;

  // Byte indices count from the least significant byte of v (index 0 = v[7:0]).
  function automatic logic [7:0] xor_bytes(input logic [XOR_BITS-1:0] v,
                                           input int lo, input int hi);
    logic [7:0] acc;
    acc = '0;
    for (int i = 0; i < MAX_MSG_BYTES; i++) begin
      if (i >= lo && i <= hi) acc = acc ^ v[8*i +: 8];
    end
    return acc;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cam_sck_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cam_sck_sync: SCK/DIN synchroniser with SCK rise/fall pulse detection    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module cam_sck_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic n_reset,
  input  logic i_sck,
  input  logic i_din,
  output logic o_sck_rise,
  output logic o_sck_fall,
  output logic o_din
);

  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_din_sync;
  logic                   r_sck_d;

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_sck_sync <= '0;
      r_din_sync <= '0;
      r_sck_d    <= 1'b0;
    end else begin
      r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], i_sck};
      r_din_sync <= {r_din_sync[SYNC_STAGES-2:0], i_din};
      r_sck_d    <= r_sck_sync[SYNC_STAGES-1];
    end
  end

  assign o_sck_rise = r_sck_sync[SYNC_STAGES-1] & ~r_sck_d;
  assign o_sck_fall = ~r_sck_sync[SYNC_STAGES-1] & r_sck_d;
  assign o_din      = r_din_sync[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/cam_link.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cam_link: host CAM serial-link slave; framed command RX, handler         |
// | dispatch, framed response TX, bit/handler timeouts.       Rev 1.0        |
// +--------------------------------------------------------------------------+
module cam_link
  import cam_pkg::*;
#(
  parameter int ARG_BYTES       = 2,
  parameter int PAY_BYTES       = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int BIT_TIMEOUT     = 1000000,
  parameter int HANDLER_TIMEOUT = 10000000
) (
  input  logic                   clk,
  input  logic                   n_reset,
  input  logic                   sck,
  input  logic                   din,
  output logic                   dout,
  output logic                   rdy,
  output logic                   cmd_valid,
  output logic [7:0]             cmd_opcode,
  output logic [8*ARG_BYTES-1:0] cmd_arg,
  output logic [8*PAY_BYTES-1:0] cmd_pay,
  input  logic                   cmd_done,
  input  logic [8*PAY_BYTES-1:0] rsp_pay,
  input  logic                   rsp_pay_valid,
  output logic                   err_pulse,
  output logic [7:0]             err_count
);

  localparam int MSG_BYTES = 4 + ARG_BYTES + PAY_BYTES;
  localparam int MSG_BITS  = 8 * MSG_BYTES;
  localparam int CW        = $clog2(MSG_BITS + 1);
  localparam int MAX_TO    = (BIT_TIMEOUT > HANDLER_TIMEOUT) ? BIT_TIMEOUT : HANDLER_TIMEOUT;
  localparam int TW        = $clog2(MAX_TO + 1);
  localparam int ARG_LSB   = MSG_BITS - 16 - 8*ARG_BYTES;

  localparam logic [CW-1:0] CNT_FULL    = CW'(MSG_BITS);
  localparam logic [TW-1:0] BIT_TO_VAL  = TW'(BIT_TIMEOUT);
  localparam logic [TW-1:0] HND_TO_LAST = TW'(HANDLER_TIMEOUT - 1);

  logic w_sck_rise;
  logic w_sck_fall;
  logic w_din;

  cam_state_t r_state;
  cam_state_t w_state_nxt;

  logic [CW-1:0]          r_cnt;
  logic [TW-1:0]          r_bit_tmr;
  logic [TW-1:0]          r_hnd_tmr;
  logic [MSG_BITS-1:0]    r_frame;
  logic [MSG_BITS-1:0]    r_tx;
  logic [8*PAY_BYTES-1:0] r_pay;
  logic [7:0]             r_status;
  logic                   r_dout;
  logic                   r_err_pulse;
  logic [7:0]             r_err_count;

  logic                   w_frame_ok;
  logic                   w_cs_ok;
  logic                   w_edge;
  logic                   w_bit_active;
  logic                   w_bit_to;
  logic                   w_hnd_to;
  logic                   w_err;
  logic [MSG_BITS-17:0]   w_rsp_body;
  logic [7:0]             w_rsp_cs;

  cam_sck_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk        (clk),
    .n_reset    (n_reset),
    .i_sck      (sck),
    .i_din      (din),
    .o_sck_rise (w_sck_rise),
    .o_sck_fall (w_sck_fall),
    .o_din      (w_din)
  );

  // Frame byte 0 sits in the MS byte; checksum and ETX are the two LS bytes.
  assign w_frame_ok = (r_frame[MSG_BITS-1 -: 8] == STX) && (r_frame[7:0] == ETX);
  assign w_cs_ok    = (xor_bytes(XOR_BITS'(r_frame), 2, MSG_BYTES-2) == r_frame[15:8]);

  assign w_rsp_body = {r_status, r_frame[MSG_BITS-9 : ARG_LSB], r_pay};
  assign w_rsp_cs   = xor_bytes(XOR_BITS'(w_rsp_body), 0, MSG_BYTES-4);

  assign w_edge       = w_sck_rise | w_sck_fall;
  assign w_bit_active = (r_state == S_RX_BITS) || (r_state == S_TX);
  assign w_bit_to     = w_bit_active && (r_bit_tmr == BIT_TO_VAL);
  assign w_hnd_to     = (r_state == S_DISPATCH) && !cmd_done && (r_hnd_tmr == HND_TO_LAST);
  assign w_err        = ((r_state == S_CHECK) && !(w_frame_ok && w_cs_ok)) || w_hnd_to || w_bit_to;

  always_ff @(posedge clk) begin
    if (!n_reset) r_state <= S_RX_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RX_IDLE:  if (w_sck_rise) w_state_nxt = S_RX_BITS;
      S_RX_BITS: begin
        if (w_bit_to)                             w_state_nxt = S_RX_IDLE;
        else if (w_sck_fall && r_cnt == CNT_FULL) w_state_nxt = S_CHECK;
      end
      S_CHECK:    w_state_nxt = (w_frame_ok && w_cs_ok) ? S_DISPATCH : S_BUILD;
      S_DISPATCH: if (cmd_done || w_hnd_to) w_state_nxt = S_BUILD;
      S_BUILD:    w_state_nxt = S_TX;
      S_TX: begin
        if (w_bit_to)                             w_state_nxt = S_RX_IDLE;
        else if (w_sck_fall && r_cnt == CNT_FULL) w_state_nxt = S_RX_IDLE;
      end
      default:    w_state_nxt = S_RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_cnt       <= '0;
      r_bit_tmr   <= '0;
      r_hnd_tmr   <= '0;
      r_frame     <= '0;
      r_tx        <= '0;
      r_pay       <= '0;
      r_status    <= ST_OK;
      r_dout      <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_err_pulse <= w_err;
      if (w_err && r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;

      if (w_edge || !w_bit_active || w_bit_to) r_bit_tmr <= '0;
      else                                     r_bit_tmr <= r_bit_tmr + TW'(1);

      if (r_state == S_DISPATCH) r_hnd_tmr <= r_hnd_tmr + TW'(1);
      else                       r_hnd_tmr <= '0;

      case (r_state)
        S_RX_IDLE, S_RX_BITS: begin
          if (w_bit_to) begin
            r_cnt <= '0;
          end else if (w_sck_rise && r_cnt != CNT_FULL) begin
            r_frame <= {r_frame[MSG_BITS-2:0], w_din};
            r_cnt   <= r_cnt + CW'(1);
          end else if (w_sck_fall && r_cnt == CNT_FULL) begin
            r_cnt <= '0;
          end
        end
        S_CHECK: begin
          r_pay <= r_frame[ARG_LSB-1 -: 8*PAY_BYTES];
          if (!w_frame_ok)   r_status <= ST_FRAME;
          else if (!w_cs_ok) r_status <= ST_CS;
          else               r_status <= ST_OK;
        end
        S_DISPATCH: begin
          // A completion in the same cycle as the timeout still counts as done.
          if (cmd_done) begin
            if (rsp_pay_valid) r_pay <= rsp_pay;
          end else if (w_hnd_to) begin
            r_status <= ST_TIMEOUT;
          end
        end
        S_BUILD: begin
          r_tx  <= {w_rsp_body, w_rsp_cs, ETX};
          r_cnt <= '0;
        end
        S_TX: begin
          if (w_bit_to) begin
            r_cnt  <= '0;
            r_dout <= 1'b0;
          end else if (w_sck_rise && r_cnt != CNT_FULL) begin
            r_dout <= r_tx[MSG_BITS-1];
            r_tx   <= {r_tx[MSG_BITS-2:0], 1'b0};
            r_cnt  <= r_cnt + CW'(1);
          end else if (w_sck_fall && r_cnt == CNT_FULL) begin
            r_dout <= 1'b0;
            r_cnt  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout       = r_dout;
  assign rdy        = (r_state == S_TX);
  assign cmd_valid  = (r_state == S_DISPATCH);
  assign cmd_opcode = r_frame[MSG_BITS-9 -: 8];
  assign cmd_arg    = r_frame[MSG_BITS-17 -: 8*ARG_BYTES];
  assign cmd_pay    = r_frame[ARG_LSB-1 -: 8*PAY_BYTES];
  assign err_pulse  = r_err_pulse;
  assign err_count  = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_cam_link.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cam_link: scoreboard bench for cam_link (PAY_BYTES=2 and =4 copies)   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_cam_link;

  localparam int HALF = 8;
  localparam int BTO  = 500;
  localparam int HTO  = 100;

  logic        clk;
  logic        n_reset_a, n_reset_b;
  logic        sck_a, sck_b, din;

  logic        dout_a, rdy_a, cmd_valid_a, cmd_done_a, rsp_pay_valid_a, err_pulse_a;
  logic [7:0]  cmd_opcode_a, err_count_a;
  logic [15:0] cmd_arg_a, cmd_pay_a, rsp_pay_a;

  logic        dout_b, rdy_b, cmd_valid_b, cmd_done_b, rsp_pay_valid_b, err_pulse_b;
  logic [7:0]  cmd_opcode_b, err_count_b;
  logic [15:0] cmd_arg_b;
  logic [31:0] cmd_pay_b, rsp_pay_b;

  logic [7:0]  frm [0:9];
  logic [7:0]  exp_a [$];
  logic [7:0]  exp_b [$];

  int n_pass     = 0;
  int n_total    = 0;
  int hmode      = 0;
  int vcyc       = 0;
  int last_vcyc  = 0;
  int n_dispatch = 0;
  int errs_a     = 0;
  int exp_err_a  = 0;
  int disp_snap;

  cam_link #(
    .ARG_BYTES(2), .PAY_BYTES(2), .SYNC_STAGES(2),
    .BIT_TIMEOUT(BTO), .HANDLER_TIMEOUT(HTO)
  ) dut_a (
    .clk(clk), .n_reset(n_reset_a), .sck(sck_a), .din(din), .dout(dout_a), .rdy(rdy_a),
    .cmd_valid(cmd_valid_a), .cmd_opcode(cmd_opcode_a), .cmd_arg(cmd_arg_a), .cmd_pay(cmd_pay_a),
    .cmd_done(cmd_done_a), .rsp_pay(rsp_pay_a), .rsp_pay_valid(rsp_pay_valid_a),
    .err_pulse(err_pulse_a), .err_count(err_count_a)
  );

  cam_link #(
    .ARG_BYTES(2), .PAY_BYTES(4), .SYNC_STAGES(2),
    .BIT_TIMEOUT(BTO), .HANDLER_TIMEOUT(HTO)
  ) dut_b (
    .clk(clk), .n_reset(n_reset_b), .sck(sck_b), .din(din), .dout(dout_b), .rdy(rdy_b),
    .cmd_valid(cmd_valid_b), .cmd_opcode(cmd_opcode_b), .cmd_arg(cmd_arg_b), .cmd_pay(cmd_pay_b),
    .cmd_done(cmd_done_b), .rsp_pay(rsp_pay_b), .rsp_pay_valid(rsp_pay_valid_b),
    .err_pulse(err_pulse_b), .err_count(err_count_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, want);
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_sck(input int sel, input logic v);
    if (sel == 0) sck_a = v;
    else          sck_b = v;
  endtask

  task automatic put_bit(input int sel, input logic b);
    din = b;
    wclk(HALF);
    set_sck(sel, 1'b1);
    wclk(HALF);
    set_sck(sel, 1'b0);
  endtask

  task automatic send_bits(input int sel, input int nbits);
    for (int i = 0; i < nbits; i++) put_bit(sel, frm[i/8][7 - (i%8)]);
  endtask

  task automatic get_bit(input int sel, output logic b);
    set_sck(sel, 1'b1);
    wclk(HALF);
    b = (sel == 0) ? dout_a : dout_b;
    set_sck(sel, 1'b0);
    wclk(HALF);
  endtask

  task automatic set_frm(input logic [79:0] v, input int n);
    for (int i = 0; i < n; i++) frm[i] = v[8*(n-1-i) +: 8];
  endtask

  task automatic fix_cs(input int n);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 1; i <= n-3; i++) x = x ^ frm[i];
    frm[n-2] = x;
  endtask

  // Expected response. mode: 0 = handler replaces payload, 1 = echo, 2 = no completion.
  task automatic predict(input int sel, input int n, input int mode);
    logic [7:0] r [0:9];
    logic [7:0] x;
    logic       fr_ok, cs_ok;
    x = 8'h00;
    for (int i = 1; i <= n-3; i++) x = x ^ frm[i];
    fr_ok = (frm[0] == 8'h02) && (frm[n-1] == 8'h03);
    cs_ok = (x == frm[n-2]);
    for (int i = 0; i < n; i++) r[i] = frm[i];
    if (!fr_ok)         r[0] = 8'h15;
    else if (!cs_ok)    r[0] = 8'h16;
    else if (mode == 2) r[0] = 8'h17;
    else                r[0] = 8'h02;
    if (fr_ok && cs_ok && mode == 0) begin
      r[4] = rsp_pay_a[15:8];
      r[5] = rsp_pay_a[7:0];
    end
    x = 8'h00;
    for (int i = 1; i <= n-3; i++) x = x ^ r[i];
    r[n-2] = x;
    r[n-1] = 8'h03;
    for (int i = 0; i < n; i++) begin
      if (sel == 0) exp_a.push_back(r[i]);
      else          exp_b.push_back(r[i]);
    end
    if (sel == 0 && r[0] != 8'h02) exp_err_a++;
  endtask

  task automatic wait_rdy(input int sel);
    int t;
    t = 0;
    while (((sel == 0) ? rdy_a : rdy_b) !== 1'b1 && t < 400) begin
      wclk(1);
      t++;
    end
    chk($sformatf("rdy_high_%0d", sel), 32'((sel == 0) ? rdy_a : rdy_b), 32'd1);
  endtask

  task automatic read_rsp(input int sel, input int nbytes, input bit full);
    logic [7:0] got, want;
    logic       b;
    wait_rdy(sel);
    for (int i = 0; i < nbytes; i++) begin
      for (int k = 7; k >= 0; k--) begin
        get_bit(sel, b);
        got[k] = b;
      end
      if ((sel == 0 ? exp_a.size() : exp_b.size()) == 0) begin
        chk("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        want = (sel == 0) ? exp_a.pop_front() : exp_b.pop_front();
        chk($sformatf("rsp%0d_byte%0d", sel, i), 32'(got), 32'(want));
      end
    end
    if (full) begin
      wclk(6);
      chk($sformatf("rdy_low_%0d", sel), 32'((sel == 0) ? rdy_a : rdy_b), 32'd0);
      chk($sformatf("dout_idle_%0d", sel), 32'((sel == 0) ? dout_a : dout_b), 32'd0);
    end
  endtask

  task automatic chk_errs(input string tag);
    chk({tag, "_err_count"}, 32'(err_count_a), 32'(exp_err_a));
    chk({tag, "_err_pulses"}, 32'(errs_a), 32'(exp_err_a));
  endtask

  // Handler for copy A: completes on the third valid cycle; mode 2 never completes
  // and instead pulses a late cmd_done once cmd_valid has dropped.
  initial begin
    cmd_done_a = 1'b0;
    forever begin
      @(negedge clk);
      cmd_done_a = 1'b0;
      if (cmd_valid_a) begin
        vcyc++;
        if (vcyc == 1) n_dispatch++;
        if (hmode != 2 && vcyc == 3) begin
          chk("opcode_a", 32'(cmd_opcode_a), 32'(frm[1]));
          chk("arg_a", 32'(cmd_arg_a), 32'({frm[2], frm[3]}));
          chk("pay_a", 32'(cmd_pay_a), 32'({frm[4], frm[5]}));
          cmd_done_a = 1'b1;
        end
      end else begin
        if (vcyc != 0) begin
          last_vcyc = vcyc;
          if (hmode == 2) cmd_done_a = 1'b1;
        end
        vcyc = 0;
      end
    end
  end

  initial begin
    cmd_done_b = 1'b0;
    forever begin
      @(negedge clk);
      if (cmd_valid_b && !cmd_done_b) begin
        chk("opcode_b", 32'(cmd_opcode_b), 32'(frm[1]));
        chk("pay_b", cmd_pay_b, {frm[4], frm[5], frm[6], frm[7]});
      end
      cmd_done_b = cmd_valid_b && !cmd_done_b;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (err_pulse_a) errs_a++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_reset_a = 1'b0; n_reset_b = 1'b0;
    sck_a = 1'b0; sck_b = 1'b0; din = 1'b0;
    rsp_pay_a = '0; rsp_pay_valid_a = 1'b0;
    rsp_pay_b = '0; rsp_pay_valid_b = 1'b0;
    wclk(4);
    chk("rst_dout", 32'(dout_a), 32'd0);
    chk("rst_rdy", 32'(rdy_a), 32'd0);
    chk("rst_cmd_valid", 32'(cmd_valid_a), 32'd0);
    chk("rst_err_pulse", 32'(err_pulse_a), 32'd0);
    chk("rst_err_count", 32'(err_count_a), 32'd0);
    n_reset_a = 1'b1; n_reset_b = 1'b1;
    wclk(4);

    // Handler replaces the payload.
    set_frm(80'h02_10_00_00_00_00_10_03, 8);
    rsp_pay_a = 16'h2104; rsp_pay_valid_a = 1'b1; hmode = 0;
    predict(0, 8, 0);
    send_bits(0, 64);
    read_rsp(0, 8, 1);
    chk("valid_cycles_done", 32'(last_vcyc), 32'd3);
    chk_errs("t1");

    // Bad checksum: no dispatch, status 0x16.
    disp_snap = n_dispatch;
    set_frm(80'h02_01_00_00_00_00_FF_03, 8);
    predict(0, 8, 0);
    send_bits(0, 64);
    read_rsp(0, 8, 1);
    chk("no_dispatch_cs", 32'(n_dispatch), 32'(disp_snap));
    chk_errs("t2");

    // Bad ETX, then a valid echo frame.
    set_frm(80'h02_22_01_02_03_04_00_04, 8);
    fix_cs(8);
    predict(0, 8, 0);
    send_bits(0, 64);
    read_rsp(0, 8, 1);
    chk_errs("t3");
    set_frm(80'h02_33_0A_0B_0C_0D_00_03, 8);
    fix_cs(8);
    rsp_pay_valid_a = 1'b0; hmode = 1;
    predict(0, 8, 1);
    send_bits(0, 64);
    read_rsp(0, 8, 1);
    chk_errs("t3b");

    // Partial frame aborted by bit inactivity, then a clean frame.
    set_frm(80'h02_44_55_66_77_88_00_03, 8);
    send_bits(0, 20);
    wclk(BTO + 10);
    wclk(10);
    exp_err_a++;
    chk_errs("t4");
    set_frm(80'h02_45_01_80_00_FF_00_03, 8);
    fix_cs(8);
    rsp_pay_a = 16'hBEEF; rsp_pay_valid_a = 1'b1; hmode = 0;
    predict(0, 8, 0);
    send_bits(0, 64);
    read_rsp(0, 8, 1);
    chk_errs("t4b");

    // Handler never completes; late cmd_done must not disturb the response.
    set_frm(80'h02_55_AA_BB_12_34_00_03, 8);
    fix_cs(8);
    hmode = 2;
    predict(0, 8, 2);
    send_bits(0, 64);
    read_rsp(0, 8, 1);
    chk("valid_cycles_timeout", 32'(last_vcyc), 32'(HTO));
    chk_errs("t5");

    // PAY_BYTES=4 copy: reset in the middle of a response.
    set_frm(80'h02_66_01_02_A1_A2_A3_A4_00_03, 10);
    fix_cs(10);
    predict(1, 10, 1);
    send_bits(1, 80);
    read_rsp(1, 3, 0);
    n_reset_b = 1'b0;
    wclk(1);
    chk("midtx_rst_dout", 32'(dout_b), 32'd0);
    chk("midtx_rst_rdy", 32'(rdy_b), 32'd0);
    chk("midtx_rst_err_count", 32'(err_count_b), 32'd0);
    chk("midtx_rst_err_pulse", 32'(err_pulse_b), 32'd0);
    n_reset_b = 1'b1;
    exp_b.delete();
    wclk(4);
    set_frm(80'h02_77_05_06_B1_B2_B3_B4_00_03, 10);
    fix_cs(10);
    predict(1, 10, 1);
    send_bits(1, 80);
    read_rsp(1, 10, 1);
    chk("arg_b_hold", 32'(cmd_arg_b), 32'h0506);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
